// File: rtl/cache_req_arbiter.sv
// Round-robin arbiter sharing one cache port among NUM_REQ requesters.
// One transaction in flight; a watchdog forces a miss response if the cache never answers.

module cache_req_arbiter_port #(
   parameter int IDX_BITS = 2,
   parameter int IDX      = 0
) (
   input  logic                Clk,
   input  logic                Rst,
   input  logic                reqVal,
   input  logic                gntEn,
   input  logic [IDX_BITS-1:0] gntIdx,
   input  logic                rspEn,
   input  logic [IDX_BITS-1:0] rspIdx,
   output logic                reqGnt,
   output logic                rspVal
);
   assign reqGnt = gntEn && (gntIdx == IDX_BITS'(IDX));
   assign rspVal = rspEn && (rspIdx == IDX_BITS'(IDX));

   // A requester must keep ReqVal up until it has seen its grant.
   holdUntilGnt: assert property (@(posedge Clk) disable iff (Rst) (reqVal && !reqGnt) |=> reqVal);
endmodule

module cache_req_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int ADDR_BITS      = 32,
   parameter int LINE_BITS      = 512,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                                Clk,
   input  logic                                Rst,
   input  logic [NUM_REQ-1:0]                  ReqVal,
   input  logic [NUM_REQ-1:0]                  ReqWr,
   input  logic [NUM_REQ-1:0][ADDR_BITS-1:0]   ReqAddr,
   input  logic [NUM_REQ-1:0][LINE_BITS-1:0]   ReqWrData,
   output logic [NUM_REQ-1:0]                  ReqGnt,
   output logic [NUM_REQ-1:0]                  RspVal,
   output logic                                RspHit,
   output logic [LINE_BITS-1:0]                RspRdData,
   output logic [ADDR_BITS-1:0]                CacheAddr,
   input  logic                                CacheAddrRdy,
   output logic                                CacheRdEn,
   output logic                                CacheWrEn,
   output logic [LINE_BITS-1:0]                CacheWrData,
   input  logic                                CacheHit,
   input  logic [LINE_BITS-1:0]                CacheRdData,
   output logic                                Busy,
   output logic                                Err
);
   localparam int IDX_BITS = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int WD_BITS  = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {IDLE, ARB, ISSUE, WAIT_RSP, RESP} stateT;

   typedef struct packed {
      logic                 wr;
      logic [ADDR_BITS-1:0] addr;
      logic [LINE_BITS-1:0] wrData;
   } cacheReqT;

   stateT               state, nextState;
   cacheReqT            curReq;
   logic [IDX_BITS-1:0] rrPtr, winIdx, arbIdx;
   logic [IDX_BITS:0]   cand;
   logic                arbFound;
   logic [WD_BITS-1:0]  wdCnt;
   logic                wdHit;
   logic                gntEn, rspEn;

   // First valid requester at or after rrPtr, wrapping modulo NUM_REQ.
   always_comb begin
      arbFound = 1'b0;
      arbIdx   = rrPtr;
      cand     = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = {1'b0, rrPtr} + (IDX_BITS+1)'(i);
         if (cand >= (IDX_BITS+1)'(NUM_REQ))
            cand = cand - (IDX_BITS+1)'(NUM_REQ);
         if (!arbFound && ReqVal[cand[IDX_BITS-1:0]]) begin
            arbFound = 1'b1;
            arbIdx   = cand[IDX_BITS-1:0];
         end
      end
   end

   assign wdHit = (wdCnt == WD_BITS'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) state <= IDLE;
      else     state <= nextState;
   end

   always_comb begin
      nextState = state;
      case (state)
         IDLE:     if (|ReqVal) nextState = ARB;
         ARB:      nextState = arbFound ? ISSUE : IDLE;
         ISSUE:    if (CacheAddrRdy) nextState = WAIT_RSP;
         WAIT_RSP: if (CacheAddrRdy || wdHit) nextState = RESP;
         RESP:     nextState = IDLE;
         default:  nextState = IDLE;
      endcase
   end

   always_comb begin
      Busy      = (state != IDLE);
      CacheRdEn = 1'b0;
      CacheWrEn = 1'b0;
      gntEn     = 1'b0;
      rspEn     = 1'b0;
      case (state)
         ARB:   gntEn = arbFound;
         ISSUE: begin
            CacheRdEn = CacheAddrRdy && !curReq.wr;
            CacheWrEn = CacheAddrRdy &&  curReq.wr;
         end
         RESP:  rspEn = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         curReq    <= '0;
         winIdx    <= '0;
         rrPtr     <= '0;
         wdCnt     <= '0;
         RspHit    <= 1'b0;
         RspRdData <= '0;
         Err       <= 1'b0;
      end else begin
         if (state == ARB && arbFound) begin
            winIdx        <= arbIdx;
            rrPtr         <= (arbIdx == IDX_BITS'(NUM_REQ - 1)) ? '0 : arbIdx + 1'b1;
            curReq.wr     <= ReqWr[arbIdx];
            curReq.addr   <= ReqAddr[arbIdx];
            curReq.wrData <= ReqWrData[arbIdx];
         end
         if (state == ISSUE && CacheAddrRdy)
            wdCnt <= '0;
         else if (state == WAIT_RSP && wdCnt != WD_BITS'(TIMEOUT_CYCLES))
            wdCnt <= wdCnt + 1'b1;
         // A real cache answer wins over a timeout landing on the same cycle.
         if (state == WAIT_RSP) begin
            if (CacheAddrRdy) begin
               RspHit    <= CacheHit;
               RspRdData <= CacheRdData;
            end else if (wdHit) begin
               RspHit    <= 1'b0;
               RspRdData <= '0;
               Err       <= 1'b1;
            end
         end
      end
   end

   assign CacheAddr   = curReq.addr;
   assign CacheWrData = curReq.wrData;

   for (genvar g = 0; g < NUM_REQ; g++) begin : genPort
      cache_req_arbiter_port #(.IDX_BITS(IDX_BITS), .IDX(g)) uPort (
         .Clk    (Clk),
         .Rst    (Rst),
         .reqVal (ReqVal[g]),
         .gntEn  (gntEn),
         .gntIdx (arbIdx),
         .rspEn  (rspEn),
         .rspIdx (winIdx),
         .reqGnt (ReqGnt[g]),
         .rspVal (RspVal[g])
      );
   end
endmodule

// File: tb/tb_cache_req_arbiter.sv
// Directed bench for cache_req_arbiter: a small cache model drives CacheAddrRdy,
// a negedge monitor logs grants/strobes/responses, and each task checks its own scenario.
module tb_cache_req_arbiter;
   localparam int NR = 4;
   localparam int AB = 32;
   localparam int LB = 512;
   localparam int TO = 8;

   logic                 Clk = 1'b0;
   logic                 Rst;
   logic [NR-1:0]        ReqVal, ReqWr, ReqGnt, RspVal;
   logic [NR-1:0][AB-1:0] ReqAddr;
   logic [NR-1:0][LB-1:0] ReqWrData;
   logic                 RspHit;
   logic [LB-1:0]        RspRdData;
   logic [AB-1:0]        CacheAddr;
   logic                 CacheAddrRdy, CacheRdEn, CacheWrEn, CacheHit;
   logic [LB-1:0]        CacheWrData, CacheRdData;
   logic                 Busy, Err;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int cacheLat = 0;
   bit cacheHang = 1'b0;

   int            gntQ[$], gntCycQ[$], rspQ[$], rspCycQ[$], strbCycQ[$];
   bit            strbWrQ[$], rspHitQ[$];
   logic [AB-1:0] strbAddrQ[$];
   logic [LB-1:0] strbDataQ[$], rspDataQ[$];
   int            rdCnt, wrCnt, bothCnt, errCyc;

   localparam logic [LB-1:0] PAT_A5 = {16{32'hA5A5_A5A5}};
   localparam logic [LB-1:0] PAT_5A = {16{32'h5A5A_5A5A}};

   cache_req_arbiter #(.NUM_REQ(NR), .ADDR_BITS(AB), .LINE_BITS(LB), .TIMEOUT_CYCLES(TO)) dut (
      .Clk(Clk), .Rst(Rst), .ReqVal(ReqVal), .ReqWr(ReqWr), .ReqAddr(ReqAddr),
      .ReqWrData(ReqWrData), .ReqGnt(ReqGnt), .RspVal(RspVal), .RspHit(RspHit),
      .RspRdData(RspRdData), .CacheAddr(CacheAddr), .CacheAddrRdy(CacheAddrRdy),
      .CacheRdEn(CacheRdEn), .CacheWrEn(CacheWrEn), .CacheWrData(CacheWrData),
      .CacheHit(CacheHit), .CacheRdData(CacheRdData), .Busy(Busy), .Err(Err)
   );

   always #5 Clk = ~Clk;

   function automatic int oneHot(input logic [NR-1:0] v);
      for (int i = 0; i < NR; i++) if (v[i]) return i;
      return -1;
   endfunction

   function automatic int qi(input int q[$], input int i);
      return (i < q.size()) ? q[i] : -1;
   endfunction

   // Cache model: after each strobe, AddrRdy drops for cacheLat cycles (or while hung).
   initial begin
      CacheAddrRdy = 1'b1;
      forever begin
         @(negedge Clk);
         if (CacheRdEn || CacheWrEn) begin
            @(posedge Clk); #1;
            if (cacheLat > 0 || cacheHang) begin
               CacheAddrRdy = 1'b0;
               for (int k = 0; k < cacheLat; k++) @(posedge Clk);
               while (cacheHang) @(posedge Clk);
               #1 CacheAddrRdy = 1'b1;
            end
         end
      end
   end

   initial begin
      errCyc = -1;
      forever begin
         @(negedge Clk);
         if (ReqGnt != '0) begin gntQ.push_back(oneHot(ReqGnt)); gntCycQ.push_back(cyc); end
         if (RspVal != '0) begin
            rspQ.push_back(oneHot(RspVal)); rspCycQ.push_back(cyc);
            rspHitQ.push_back(RspHit); rspDataQ.push_back(RspRdData);
         end
         if (CacheRdEn || CacheWrEn) begin
            strbCycQ.push_back(cyc); strbWrQ.push_back(CacheWrEn);
            strbAddrQ.push_back(CacheAddr); strbDataQ.push_back(CacheWrData);
         end
         if (CacheRdEn) rdCnt++;
         if (CacheWrEn) wrCnt++;
         if (CacheRdEn && CacheWrEn) bothCnt++;
         if (Err && errCyc < 0) errCyc = cyc;
         cyc++;
      end
   end

   task automatic clearLogs();
      gntQ.delete(); gntCycQ.delete(); rspQ.delete(); rspCycQ.delete(); strbCycQ.delete();
      strbWrQ.delete(); rspHitQ.delete(); strbAddrQ.delete(); strbDataQ.delete(); rspDataQ.delete();
      rdCnt = 0; wrCnt = 0; bothCnt = 0; errCyc = -1;
   endtask

   task automatic grabGnt(input bit drop, output int idx, output bit ok);
      ok = 1'b0; idx = -1;
      for (int k = 0; k < 60; k++) begin
         @(negedge Clk);
         if (ReqGnt != '0) begin ok = 1'b1; idx = oneHot(ReqGnt); break; end
      end
      @(posedge Clk); #1;
      if (ok && drop) ReqVal[idx] = 1'b0;
   endtask

   task automatic waitRsp(input int n, input int maxCyc, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < maxCyc; k++) begin
         @(posedge Clk);
         if (rspQ.size() >= n) begin ok = 1'b1; break; end
      end
      #1;
   endtask

   task automatic test_reset();
      Rst = 1'b1; ReqVal = '0; ReqWr = '0; ReqAddr = '0; ReqWrData = '0;
      CacheHit = 1'b0; CacheRdData = '0;
      repeat (3) @(posedge Clk); #1;
      checks++; if ({ReqGnt, RspVal, RspHit, CacheRdEn, CacheWrEn, Busy, Err} !== '0) begin
         failures++; $display("FAIL reset_ctrl got %b want 0", {ReqGnt, RspVal, RspHit, CacheRdEn, CacheWrEn, Busy, Err}); end
      checks++; if (CacheAddr !== '0) begin failures++; $display("FAIL reset_addr got %h want 0", CacheAddr); end
      checks++; if (RspRdData !== '0 || CacheWrData !== '0) begin failures++; $display("FAIL reset_data got nonzero want 0"); end
      Rst = 1'b0;
      repeat (2) @(posedge Clk); #1;
      checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL idle_busy got %b want 0", Busy); end
   endtask

   task automatic test_round_robin();
      int idx; bit ok;
      clearLogs(); cacheLat = 0;
      for (int i = 0; i < NR; i++) ReqAddr[i] = AB'(32'h100 * (i + 1));
      ReqWr = '0; ReqVal = 4'hF;
      for (int g = 0; g < 8; g++) begin
         grabGnt(g >= 4, idx, ok);
         checks++; if (!ok) begin failures++; $display("FAIL rr_gnt_wait grant %0d got none want one", g); end
      end
      waitRsp(8, 40, ok);
      checks++; if (!ok) begin failures++; $display("FAIL rr_rsp_wait got %0d rsps want 8", rspQ.size()); end
      checks++; if (gntQ.size() != 8) begin failures++; $display("FAIL rr_gnt_count got %0d want 8", gntQ.size()); end
      for (int g = 0; g < 8; g++) begin
         checks++; if (qi(gntQ, g) != g % 4) begin failures++; $display("FAIL rr_order[%0d] got %0d want %0d", g, qi(gntQ, g), g % 4); end
         checks++; if (qi(rspQ, g) != g % 4) begin failures++; $display("FAIL rr_rsp[%0d] got %0d want %0d", g, qi(rspQ, g), g % 4); end
      end
      checks++; if (rdCnt != 8 || wrCnt != 0 || bothCnt != 0) begin
         failures++; $display("FAIL rr_strobes got rd=%0d wr=%0d both=%0d want 8/0/0", rdCnt, wrCnt, bothCnt); end
   endtask

   task automatic test_single_read();
      int idx, t0; bit ok, ok2;
      clearLogs(); cacheLat = 3; CacheHit = 1'b1; CacheRdData = PAT_A5;
      ReqWr = '0; ReqAddr[1] = 32'h1000;
      t0 = cyc; ReqVal[1] = 1'b1;
      grabGnt(1'b1, idx, ok);
      waitRsp(1, 40, ok2);
      checks++; if (!ok || idx != 1) begin failures++; $display("FAIL rd_gnt got %0d want 1", idx); end
      checks++; if (qi(gntCycQ, 0) != t0 + 1) begin failures++; $display("FAIL rd_gnt_lat got %0d want %0d", qi(gntCycQ, 0), t0 + 1); end
      checks++; if (qi(strbCycQ, 0) != t0 + 2) begin failures++; $display("FAIL rd_strb_lat got %0d want %0d", qi(strbCycQ, 0), t0 + 2); end
      checks++; if (!ok2 || qi(rspCycQ, 0) != t0 + 7) begin failures++; $display("FAIL rd_rsp_lat got %0d want %0d", qi(rspCycQ, 0), t0 + 7); end
      checks++; if (qi(rspQ, 0) != 1) begin failures++; $display("FAIL rd_rsp_idx got %0d want 1", qi(rspQ, 0)); end
      checks++; if (rspHitQ.size() != 1 || rspHitQ[0] !== 1'b1) begin failures++; $display("FAIL rd_hit got %0d entries want hit=1", rspHitQ.size()); end
      checks++; if (rspDataQ.size() != 1 || rspDataQ[0] !== PAT_A5) begin failures++; $display("FAIL rd_data got wrong line want A5 pattern"); end
      checks++; if (strbAddrQ.size() != 1 || strbAddrQ[0] !== 32'h1000) begin failures++; $display("FAIL rd_addr got wrong addr want 1000"); end
      checks++; if (rdCnt != 1 || wrCnt != 0) begin failures++; $display("FAIL rd_strobes got rd=%0d wr=%0d want 1/0", rdCnt, wrCnt); end
   endtask

   task automatic test_write_contention();
      int idx, idx2; bit ok, ok2, ok3;
      clearLogs(); cacheLat = 4; CacheHit = 1'b1; CacheRdData = PAT_A5;
      ReqWr = 4'b0100; ReqAddr[2] = 32'h2000; ReqWrData[2] = PAT_5A; ReqAddr[0] = 32'h3000;
      ReqVal[2] = 1'b1;
      grabGnt(1'b1, idx, ok);
      @(posedge Clk); #1;
      ReqVal[0] = 1'b1;
      grabGnt(1'b1, idx2, ok2);
      waitRsp(2, 40, ok3);
      checks++; if (!ok || idx != 2) begin failures++; $display("FAIL wr_gnt got %0d want 2", idx); end
      checks++; if (!ok2 || idx2 != 0) begin failures++; $display("FAIL wr_gnt2 got %0d want 0", idx2); end
      checks++; if (strbWrQ.size() != 2 || strbWrQ[0] !== 1'b1 || strbWrQ[1] !== 1'b0) begin
         failures++; $display("FAIL wr_kind got %0d strobes want write then read", strbWrQ.size()); end
      checks++; if (strbDataQ.size() < 1 || strbDataQ[0] !== PAT_5A || strbAddrQ[0] !== 32'h2000) begin
         failures++; $display("FAIL wr_payload got wrong addr/data want 2000/5A pattern"); end
      checks++; if (wrCnt != 1 || rdCnt != 1 || bothCnt != 0) begin
         failures++; $display("FAIL wr_strobes got rd=%0d wr=%0d both=%0d want 1/1/0", rdCnt, wrCnt, bothCnt); end
      checks++; if (!ok3 || qi(rspQ, 0) != 2 || qi(gntCycQ, 1) <= qi(rspCycQ, 0)) begin
         failures++; $display("FAIL wr_order got gnt0@%0d rsp2@%0d want gnt after rsp", qi(gntCycQ, 1), qi(rspCycQ, 0)); end
   endtask

   task automatic test_wrap();
      int a, b, c; bit ok;
      clearLogs(); cacheLat = 0; ReqWr = '0;
      ReqVal[2] = 1'b1;
      grabGnt(1'b1, a, ok);
      waitRsp(1, 30, ok);
      ReqVal = 4'b1001;
      grabGnt(1'b1, b, ok);
      grabGnt(1'b1, c, ok);
      waitRsp(3, 30, ok);
      checks++; if (!ok) begin failures++; $display("FAIL wrap_rsp_wait got %0d rsps want 3", rspQ.size()); end
      checks++; if (qi(gntQ, 0) != 2 || qi(gntQ, 1) != 3 || qi(gntQ, 2) != 0) begin
         failures++; $display("FAIL wrap_order got %0d,%0d,%0d want 2,3,0", qi(gntQ, 0), qi(gntQ, 1), qi(gntQ, 2)); end
   endtask

   task automatic test_timeout();
      int idx, s; bit ok;
      clearLogs(); cacheLat = 0; cacheHang = 1'b1; CacheHit = 1'b1; CacheRdData = PAT_A5;
      ReqWr = '0; ReqAddr[1] = 32'h4000; ReqVal[1] = 1'b1;
      grabGnt(1'b1, idx, ok);
      waitRsp(1, 40, ok);
      s = qi(strbCycQ, 0);
      checks++; if (!ok || qi(rspQ, 0) != 1) begin failures++; $display("FAIL to_rsp got %0d want 1", qi(rspQ, 0)); end
      checks++; if (qi(rspCycQ, 0) != s + TO + 1) begin failures++; $display("FAIL to_rsp_lat got %0d want %0d", qi(rspCycQ, 0), s + TO + 1); end
      checks++; if (errCyc != s + TO + 1) begin failures++; $display("FAIL to_err_cyc got %0d want %0d", errCyc, s + TO + 1); end
      checks++; if (rspHitQ.size() != 1 || rspHitQ[0] !== 1'b0) begin failures++; $display("FAIL to_hit got hit=1 or none want 0"); end
      checks++; if (rspDataQ.size() != 1 || rspDataQ[0] !== '0) begin failures++; $display("FAIL to_data got nonzero want 0"); end
      cacheHang = 1'b0;
      repeat (5) @(posedge Clk); #1;
      checks++; if (Err !== 1'b1 || Busy !== 1'b0) begin failures++; $display("FAIL to_sticky got err=%b busy=%b want 1/0", Err, Busy); end
   endtask

   task automatic test_reset_mid();
      int idx, a, b, nRd; bit ok;
      clearLogs(); cacheLat = 0; cacheHang = 1'b1; ReqWr = '0; ReqAddr[1] = 32'h5000;
      ReqVal[1] = 1'b1;
      grabGnt(1'b1, idx, ok);
      repeat (2) @(posedge Clk); #1;
      checks++; if (Busy !== 1'b1) begin failures++; $display("FAIL rst_busy_before got %b want 1", Busy); end
      @(negedge Clk); #2;
      Rst = 1'b1; #1;
      checks++; if ({ReqGnt, RspVal, RspHit, CacheRdEn, CacheWrEn, Busy, Err} !== '0) begin
         failures++; $display("FAIL rst_ctrl got %b want 0", {ReqGnt, RspVal, RspHit, CacheRdEn, CacheWrEn, Busy, Err}); end
      checks++; if (CacheAddr !== '0 || RspRdData !== '0) begin failures++; $display("FAIL rst_regs got addr=%h want 0", CacheAddr); end
      nRd = rdCnt;
      @(posedge Clk); #1;
      Rst = 1'b0; cacheHang = 1'b0;
      repeat (4) @(posedge Clk); #1;
      checks++; if (rspQ.size() != 0 || rdCnt != nRd) begin
         failures++; $display("FAIL rst_quiet got rsps=%0d strobes=%0d want 0/%0d", rspQ.size(), rdCnt, nRd); end
      ReqVal = 4'b0101;
      grabGnt(1'b1, a, ok);
      grabGnt(1'b1, b, ok);
      waitRsp(2, 40, ok);
      checks++; if (a != 0 || b != 2) begin failures++; $display("FAIL rst_rrptr got %0d,%0d want 0,2", a, b); end
      checks++; if (!ok || qi(rspQ, 0) != 0) begin failures++; $display("FAIL rst_resume got %0d want 0", qi(rspQ, 0)); end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_single_read();
      test_write_contention();
      test_wrap();
      test_timeout();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got no finish want finish");
      $fatal(1);
   end
endmodule
